// File: rtl/monopulse_feeder_if.sv
// Flag/data link between the monopulse feeder (master) and the feature-extraction engine (slave).
interface monopulse_feeder_if;
  logic [15:0] Monopulse_data_out;
  logic        FeatureExtraction_flag;
  logic        Over_flag;

  modport master (
    output Monopulse_data_out,
    output FeatureExtraction_flag,
    input  Over_flag
  );

  modport slave (
    input  Monopulse_data_out,
    input  FeatureExtraction_flag,
    output Over_flag
  );
endinterface

// File: rtl/monopulse_feeder.sv
// Threshold-captures single discharge pulses into a buffer and streams them,
// header first, to the feature-extraction engine over the flag/data link.
module monopulse_feeder #(
  parameter int MAX_LEN = 250,
  parameter int MIN_LEN = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                       Clk_arithmetic,
  input  logic                       Rst,
  input  logic [7:0]                 Sample_in,
  input  logic                       Sample_valid,
  input  logic [7:0]                 Threshold,
  monopulse_feeder_if.master         fe,
  output logic [15:0]                Pulse_len,
  output logic                       Truncated,
  output logic [15:0]                Drop_cnt,
  output logic                       Timeout_err,
  output logic                       Busy
);

  localparam int AW = $clog2(MAX_LEN + 3);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    CAPTURE  = 2'd1,
    SEND     = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [15:0]   len_r, len_nxt_s;
  logic [15:0]   k_r, k_nxt_s;
  logic [15:0]   wait_r, wait_nxt_s;
  logic          prev_above_r, prev_above_nxt_s;
  logic [15:0]   data_r, data_nxt_s;
  logic          flag_r, flag_nxt_s;
  logic [15:0]   pulse_len_r, pulse_len_nxt_s;
  logic          trunc_r, trunc_nxt_s;
  logic [15:0]   drop_r, drop_nxt_s;
  logic          terr_r, terr_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [AW-1:0] rd_idx_s;
  logic          above_s, start_s, over_s, timeout_s;
  logic [7:0]    pulse_mem_r [0:MAX_LEN-1];

  assign above_s   = (Sample_in > Threshold);
  assign start_s   = Sample_valid && above_s && !prev_above_r;
  assign over_s    = fe.Over_flag;
  assign timeout_s = (wait_r == 16'(TIMEOUT - 1));
  // Word for SEND cycle k+1 is fetched during cycle k, so index is k-2.
  assign rd_idx_s  = k_r[AW-1:0] - AW'(2);

  assign fe.Monopulse_data_out     = data_r;
  assign fe.FeatureExtraction_flag = flag_r;
  assign Pulse_len                 = pulse_len_r;
  assign Truncated                 = trunc_r;
  assign Drop_cnt                  = drop_r;
  assign Timeout_err               = terr_r;
  assign Busy                      = busy_r;

  // State, counters and registered outputs.
  always_ff @(posedge Clk_arithmetic) begin
    if (Rst) begin
      state_r      <= ARMED;
      len_r        <= 16'd0;
      k_r          <= 16'd0;
      wait_r       <= 16'd0;
      prev_above_r <= 1'b0;
      data_r       <= 16'd0;
      flag_r       <= 1'b0;
      pulse_len_r  <= 16'd0;
      trunc_r      <= 1'b0;
      drop_r       <= 16'd0;
      terr_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      len_r        <= len_nxt_s;
      k_r          <= k_nxt_s;
      wait_r       <= wait_nxt_s;
      prev_above_r <= prev_above_nxt_s;
      data_r       <= data_nxt_s;
      flag_r       <= flag_nxt_s;
      pulse_len_r  <= pulse_len_nxt_s;
      trunc_r      <= trunc_nxt_s;
      drop_r       <= drop_nxt_s;
      terr_r       <= terr_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  // Pulse sample buffer; contents need no reset.
  always_ff @(posedge Clk_arithmetic) begin
    if (mem_we_s) begin
      pulse_mem_r[mem_addr_s] <= Sample_in;
    end
  end

  // Next-state, length/cycle counters and buffer write control.
  always_comb begin
    state_nxt_s      = state_r;
    len_nxt_s        = len_r;
    k_nxt_s          = k_r;
    wait_nxt_s       = wait_r;
    mem_we_s         = 1'b0;
    mem_addr_s       = {AW{1'b0}};
    if (Sample_valid) begin
      prev_above_nxt_s = above_s;
    end else begin
      prev_above_nxt_s = prev_above_r;
    end
    case (state_r)
      ARMED: begin
        if (start_s) begin
          state_nxt_s = CAPTURE;
          len_nxt_s   = 16'd1;
          mem_we_s    = 1'b1;
          mem_addr_s  = {AW{1'b0}};
        end else begin
          state_nxt_s = ARMED;
        end
      end
      CAPTURE: begin
        if (Sample_valid && above_s) begin
          if (len_r < 16'(MAX_LEN)) begin
            mem_we_s   = 1'b1;
            mem_addr_s = len_r[AW-1:0];
            len_nxt_s  = len_r + 16'd1;
          end else begin
            len_nxt_s  = len_r;
          end
        end else if (Sample_valid) begin
          if (len_r < 16'(MIN_LEN)) begin
            state_nxt_s = ARMED;
          end else begin
            state_nxt_s = SEND;
            k_nxt_s     = 16'd0;
          end
        end else begin
          state_nxt_s = CAPTURE;
        end
      end
      SEND: begin
        if (k_r == len_r + 16'd2) begin
          state_nxt_s = WAIT_ACK;
          wait_nxt_s  = 16'd0;
        end else begin
          k_nxt_s     = k_r + 16'd1;
        end
      end
      WAIT_ACK: begin
        if (over_s || timeout_s) begin
          state_nxt_s = ARMED;
        end else begin
          wait_nxt_s  = wait_r + 16'd1;
        end
      end
      default: begin
        state_nxt_s = ARMED;
      end
    endcase
  end

  // Next values of the registered outputs, one cycle ahead of their use.
  always_comb begin
    data_nxt_s      = data_r;
    flag_nxt_s      = flag_r;
    pulse_len_nxt_s = pulse_len_r;
    trunc_nxt_s     = trunc_r;
    terr_nxt_s      = 1'b0;
    busy_nxt_s      = (state_nxt_s != ARMED);
    if ((state_r == SEND || state_r == WAIT_ACK) && start_s && drop_r != 16'hFFFF) begin
      drop_nxt_s = drop_r + 16'd1;
    end else begin
      drop_nxt_s = drop_r;
    end
    case (state_r)
      ARMED: begin
        flag_nxt_s = 1'b0;
        data_nxt_s = 16'd0;
        if (start_s) begin
          trunc_nxt_s = 1'b0;
        end else begin
          trunc_nxt_s = trunc_r;
        end
      end
      CAPTURE: begin
        if (Sample_valid && above_s && len_r >= 16'(MAX_LEN)) begin
          trunc_nxt_s = 1'b1;
        end else if (Sample_valid && !above_s && len_r >= 16'(MIN_LEN)) begin
          pulse_len_nxt_s = len_r;
          data_nxt_s      = len_r;
          flag_nxt_s      = 1'b1;
        end else begin
          trunc_nxt_s = trunc_r;
        end
      end
      SEND: begin
        if (k_r == len_r + 16'd2) begin
          data_nxt_s = 16'd0;
        end else if (k_r < 16'd2) begin
          data_nxt_s = len_r;
        end else begin
          data_nxt_s = {8'h00, pulse_mem_r[rd_idx_s]};
        end
      end
      WAIT_ACK: begin
        data_nxt_s = 16'd0;
        if (over_s) begin
          flag_nxt_s = 1'b0;
        end else if (timeout_s) begin
          flag_nxt_s = 1'b0;
          terr_nxt_s = 1'b1;
        end else begin
          flag_nxt_s = 1'b1;
        end
      end
      default: begin
        flag_nxt_s = 1'b0;
        data_nxt_s = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_monopulse_feeder.sv
// Directed bench: stimulus queues expected transfers, a negedge monitor pops and compares them.
module tb_monopulse_feeder;

  logic        clk = 1'b0;
  logic        Rst;
  logic [7:0]  Sample_in;
  logic        Sample_valid;
  logic [7:0]  Threshold;
  logic [15:0] Pulse_len;
  logic        Truncated;
  logic [15:0] Drop_cnt;
  logic        Timeout_err;
  logic        Busy;

  monopulse_feeder_if fe ();

  monopulse_feeder dut (
    .Clk_arithmetic (clk),
    .Rst            (Rst),
    .Sample_in      (Sample_in),
    .Sample_valid   (Sample_valid),
    .Threshold      (Threshold),
    .fe             (fe),
    .Pulse_len      (Pulse_len),
    .Truncated      (Truncated),
    .Drop_cnt       (Drop_cnt),
    .Timeout_err    (Timeout_err),
    .Busy           (Busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] word_q  [$];
  logic [15:0] len_q   [$];
  logic        trunc_q [$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] v);
    Sample_in    = v;
    Sample_valid = 1'b1;
    step();
    Sample_valid = 1'b0;
  endtask

  task automatic expect_hdr(input logic [15:0] len, input logic trunc);
    len_q.push_back(len);
    trunc_q.push_back(trunc);
    repeat (3) word_q.push_back(len);
  endtask

  task automatic over_pulse();
    fe.Over_flag = 1'b1;
    step();
    fe.Over_flag = 1'b0;
  endtask

  // Monitor: each transfer starts on a flag rising edge and ends on the terminating zero word.
  initial begin
    logic        active;
    logic        flag_d;
    logic [15:0] e;
    active = 1'b0;
    flag_d = 1'b0;
    forever begin
      @(negedge clk);
      if (fe.FeatureExtraction_flag && !flag_d) begin
        if (len_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_xfer: got flag rise with header %0d, expected none", fe.Monopulse_data_out);
        end else begin
          chk("pulse_len", Pulse_len, len_q.pop_front());
          chk("truncated", {15'd0, Truncated}, {15'd0, trunc_q.pop_front()});
          active = 1'b1;
        end
      end
      if (active && fe.FeatureExtraction_flag) begin
        if (word_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL extra_word: got %0d, expected no word", fe.Monopulse_data_out);
          active = 1'b0;
        end else begin
          e = word_q.pop_front();
          chk("xfer_word", fe.Monopulse_data_out, e);
          if (e == 16'd0) active = 1'b0;
        end
      end else begin
        active = 1'b0;
      end
      flag_d = fe.FeatureExtraction_flag;
    end
  end

  initial begin
    int bad;
    int n;
    Rst          = 1'b1;
    Sample_in    = 8'd0;
    Sample_valid = 1'b0;
    Threshold    = 8'd20;
    fe.Over_flag = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_flag", {15'd0, fe.FeatureExtraction_flag}, 16'd0);
    chk("rst_data", fe.Monopulse_data_out, 16'd0);
    chk("rst_busy", {15'd0, Busy}, 16'd0);
    chk("rst_drop", Drop_cnt, 16'd0);
    chk("rst_len", Pulse_len, 16'd0);
    chk("rst_terr", {15'd0, Timeout_err}, 16'd0);
    Rst = 1'b0;
    step();

    // Basic 4-sample pulse.
    expect_hdr(16'd4, 1'b0);
    word_q.push_back(16'd30); word_q.push_back(16'd40);
    word_q.push_back(16'd60); word_q.push_back(16'd35);
    word_q.push_back(16'd0);
    sample(8'd5); sample(8'd30); sample(8'd40); sample(8'd60); sample(8'd35); sample(8'd10);
    repeat (12) step();
    @(negedge clk);
    chk("t1_flag_held", {15'd0, fe.FeatureExtraction_flag}, 16'd1);
    chk("t1_wait_data", fe.Monopulse_data_out, 16'd0);
    chk("t1_busy", {15'd0, Busy}, 16'd1);
    over_pulse();
    @(negedge clk);
    chk("t1_flag_drop", {15'd0, fe.FeatureExtraction_flag}, 16'd0);
    chk("t1_idle", {15'd0, Busy}, 16'd0);
    step();

    // Length 2 pulse is discarded silently.
    sample(8'd5); sample(8'd25); sample(8'd30); sample(8'd5);
    repeat (5) step();
    @(negedge clk);
    chk("t2_flag", {15'd0, fe.FeatureExtraction_flag}, 16'd0);
    chk("t2_busy", {15'd0, Busy}, 16'd0);
    chk("t2_drop", Drop_cnt, 16'd0);

    // 260 samples truncate to 250.
    expect_hdr(16'd250, 1'b1);
    repeat (250) word_q.push_back(16'd100);
    word_q.push_back(16'd0);
    repeat (260) sample(8'd100);
    sample(8'd0);
    repeat (260) step();
    @(negedge clk);
    chk("t3_trunc", {15'd0, Truncated}, 16'd1);
    chk("t3_len", Pulse_len, 16'd250);
    over_pulse();
    step();

    // MIN_LEN pulse sent; second pulse during WAIT_ACK is dropped.
    expect_hdr(16'd3, 1'b0);
    word_q.push_back(16'd50); word_q.push_back(16'd60); word_q.push_back(16'd70);
    word_q.push_back(16'd0);
    sample(8'd50); sample(8'd60); sample(8'd70); sample(8'd0);
    repeat (10) step();
    sample(8'd80); sample(8'd90); sample(8'd0);
    @(negedge clk);
    chk("t4_drop", Drop_cnt, 16'd1);
    chk("t4_flag_held", {15'd0, fe.FeatureExtraction_flag}, 16'd1);
    over_pulse();
    repeat (3) step();
    // Third pulse; an Over_flag during SEND must be ignored.
    expect_hdr(16'd4, 1'b0);
    word_q.push_back(16'd21); word_q.push_back(16'd22);
    word_q.push_back(16'd23); word_q.push_back(16'd24);
    word_q.push_back(16'd0);
    sample(8'd21); sample(8'd22); sample(8'd23); sample(8'd24); sample(8'd0);
    repeat (2) step();
    over_pulse();
    repeat (8) step();
    @(negedge clk);
    chk("t4_over_in_send", {15'd0, fe.FeatureExtraction_flag}, 16'd1);
    over_pulse();
    @(negedge clk);
    chk("t4_flag_drop", {15'd0, fe.FeatureExtraction_flag}, 16'd0);
    chk("t4_drop_final", Drop_cnt, 16'd1);
    step();

    // No Over_flag: timeout after 1024 WAIT_ACK cycles (SEND of len 3 is 6 cycles).
    expect_hdr(16'd3, 1'b0);
    word_q.push_back(16'd30); word_q.push_back(16'd31); word_q.push_back(16'd32);
    word_q.push_back(16'd0);
    sample(8'd30); sample(8'd31); sample(8'd32); sample(8'd0);
    n = 0;
    @(negedge clk);
    while (!fe.FeatureExtraction_flag && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_flag_rise", {15'd0, fe.FeatureExtraction_flag}, 16'd1);
    bad = 0;
    for (int i = 0; i < 1029; i++) begin
      @(negedge clk);
      if (Timeout_err !== 1'b0) bad++;
    end
    chk("t5_no_early_terr", 16'(bad), 16'd0);
    chk("t5_flag_before", {15'd0, fe.FeatureExtraction_flag}, 16'd1);
    @(negedge clk);
    chk("t5_terr", {15'd0, Timeout_err}, 16'd1);
    chk("t5_flag_off", {15'd0, fe.FeatureExtraction_flag}, 16'd0);
    chk("t5_rearmed", {15'd0, Busy}, 16'd0);
    @(negedge clk);
    chk("t5_terr_onecyc", {15'd0, Timeout_err}, 16'd0);
    step();

    // Reset at SEND cycle k=5.
    len_q.push_back(16'd6);
    trunc_q.push_back(1'b0);
    repeat (3) word_q.push_back(16'd6);
    word_q.push_back(16'd40); word_q.push_back(16'd41); word_q.push_back(16'd42);
    sample(8'd40); sample(8'd41); sample(8'd42); sample(8'd43); sample(8'd44); sample(8'd45);
    sample(8'd0);
    repeat (5) step();
    Rst = 1'b1;
    step();
    @(negedge clk);
    chk("t6_flag", {15'd0, fe.FeatureExtraction_flag}, 16'd0);
    chk("t6_data", fe.Monopulse_data_out, 16'd0);
    chk("t6_drop", Drop_cnt, 16'd0);
    chk("t6_busy", {15'd0, Busy}, 16'd0);
    Rst = 1'b0;
    repeat (3) step();

    chk("sb_words_left", 16'(word_q.size()), 16'd0);
    chk("sb_xfers_left", 16'(len_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/monopulse_feeder.md
Name: monopulse_feeder

Overview:
- Captures single discharge pulses from the 8-bit sample stream by threshold detection into an internal buffer.
- Streams each captured pulse to the feature-extraction engine: a length header word first, then the samples.
- Drives the FeatureExtraction_flag request and closes each transfer on the engine's Over_flag completion strobe.
- Sits between the sampling/DDR2 path and the feature-extraction engine; it is the transmitter side of that flag/data interface.

Parameters:
- MAX_LEN, 250, buffer depth and maximum stored samples per pulse (≤ 251).
- MIN_LEN, 3, pulses shorter than this are discarded, never sent.
- TIMEOUT, 1024, cycles in WAIT_ACK before the transfer is aborted.

Ports:
- Clk_arithmetic  in  1  system clock; all logic on its rising edge.
- Rst  in  1  synchronous active-high reset.
- Sample_in  in  8  sample value.
- Sample_valid  in  1  Sample_in qualifier.
- Threshold  in  8  capture threshold; a sample is "above" when Sample_in > Threshold.
- Over_flag  in  1  one-cycle completion strobe from the feature engine.
- Monopulse_data_out  out  16  header/sample word to the feature engine.
- FeatureExtraction_flag  out  1  transfer request, level.
- Pulse_len  out  16  length of the pulse being sent.
- Truncated  out  1  current pulse exceeded MAX_LEN.
- Drop_cnt  out  16  pulses dropped while busy, saturating.
- Timeout_err  out  1  one-cycle pulse on WAIT_ACK timeout.
- Busy  out  1  high in any state except ARMED.

Behaviour:
- Interface: one clock, Clk_arithmetic. Reset Rst is synchronous and active-high.
- Reset values: all outputs 0, state ARMED, internal length/counters 0, prev_above 0. Buffer contents are don't-care.
- Reset mid-operation: the in-flight pulse is abandoned and FeatureExtraction_flag drops in the cycle after Rst is sampled.
- prev_above: registers the "above" status of the last valid sample.
- Pulse start: a valid above sample while prev_above = 0.
- ARMED:
  - On a valid above sample, write it to buf[0], set len = 1, Truncated = 0, go to CAPTURE.
- CAPTURE, per valid sample:
  - Above and len < MAX_LEN: write buf[len], len += 1.
  - Above and len = MAX_LEN: discard the sample, set Truncated = 1.
  - Not above: the sample is not stored. If len < MIN_LEN, go to ARMED (pulse silently discarded). Otherwise latch Pulse_len = len and go to SEND.
  - Invalid cycles do not change state.
- SEND (k = cycle index from 0; FeatureExtraction_flag = 1 from k = 0):
  - k = 0, 1, 2: Monopulse_data_out = Pulse_len.
  - k = 3+i, for i = 0 .. Pulse_len−1: Monopulse_data_out = {8'h00, buf[i]}.
  - After the last sample: output 16'h0000, go to WAIT_ACK.
  - Data is registered and buffer reads are pipelined so each word appears exactly on its cycle k.
- WAIT_ACK:
  - Flag stays 1 and data stays 0.
  - Over_flag = 1: flag = 0 next cycle, go to ARMED.
  - TIMEOUT cycles with no Over_flag: Timeout_err = 1 for one cycle, flag = 0, go to ARMED.
- Over_flag seen during SEND: ignored. The transfer completes and WAIT_ACK still requires a later Over_flag.
- Flag low time: FeatureExtraction_flag stays low at least 2 cycles between transfers, so the engine sees a clean rising edge.
- Drop counting: Drop_cnt += 1 (saturating at 16'hFFFF) on each pulse start detected in SEND or WAIT_ACK. Drops are never retried. Samples in these states are otherwise ignored.
- Simultaneous events:
  - Pulse end and pulse start cannot coincide on one sample.
  - The ARMED re-entry cycle accepts a pulse start only when prev_above = 0. A pulse already in progress at re-entry is not captured mid-way.
- Widths:
  - len is a 16-bit counter and saturates at MAX_LEN.
  - The header is the zero-extended 16-bit length.

Test Plan:
- Threshold = 20; valid samples 5,30,40,60,35,10 → SEND with header 4 on k = 0..2, words 30,40,60,35 on k = 3..6, then 0. Flag held until Over_flag; drops 1 cycle after it.
- Threshold = 20; samples 5,25,30,5 (len 2 < MIN_LEN) → no flag, state ARMED, Drop_cnt = 0.
- 260 consecutive samples of value 100, then 0 → Pulse_len = 250, Truncated = 1, exactly 250 sample words sent.
- Second pulse starts during WAIT_ACK → Drop_cnt = 1, no second transfer. A third pulse after Over_flag is sent normally.
- No Over_flag after SEND → Timeout_err pulse at TIMEOUT cycles into WAIT_ACK, flag = 0, block re-armed.
- Rst asserted at k = 5 of SEND → next cycle flag = 0, Monopulse_data_out = 0, Drop_cnt = 0, Busy = 0.
